// File: rtl/game_pkg.sv
// Shared state codes for the game controller and the blocks that decode its dataout.
// Also holds the width helper used to size the level and respawn-timer counters.
package game_pkg;

  localparam logic [2:0] ST_START    = 3'd0;
  localparam logic [2:0] ST_PLAYING  = 3'd1;
  localparam logic [2:0] ST_PAUSE    = 3'd2;
  localparam logic [2:0] ST_RESET    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;
  localparam logic [2:0] ST_RESPAWN  = 3'd5;
  localparam logic [2:0] ST_WIN      = 3'd6;

  typedef enum logic [2:0] {
    S_START    = ST_START,
    S_PLAYING  = ST_PLAYING,
    S_PAUSE    = ST_PAUSE,
    S_RESET    = ST_RESET,
    S_GAMEOVER = ST_GAMEOVER,
    S_RESPAWN  = ST_RESPAWN,
    S_WIN      = ST_WIN
  } state_t;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Button/event inputs and state outputs of the game controller.
// master drives the buttons and events; slave is the controller itself.
interface game_ctrl_fsm_if #(
  parameter int LW = 2,
  parameter int VW = 3
);
  logic          reset;
  logic          startGame;
  logic          pauseGame;
  logic          dead;
  logic          level_done;
  logic [2:0]    dataout;
  logic [LW-1:0] lives;
  logic [VW-1:0] level;
  logic          run_en;
  logic          state_chg;

  modport master (
    output reset, startGame, pauseGame, dead, level_done,
    input  dataout, lives, level, run_en, state_chg
  );

  modport slave (
    input  reset, startGame, pauseGame, dead, level_done,
    output dataout, lives, level, run_en, state_chg
  );
endinterface

// File: rtl/game_ctrl_fsm_rise_detect.sv
// Rising-edge detector with a one-cycle history register.
// History resets to 1 so a button held through reset produces no pulse.
module rise_detect (
  input  logic clk,
  input  logic resetFSM,
  input  logic in,
  output logic pulse
);
  logic in_q;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset branch.
  always_ff @(posedge clk or posedge resetFSM) begin
    if (resetFSM) in_q <= 1'b1;
    else          in_q <= in;
  end

  assign pulse = in & ~in_q;
endmodule

// File: rtl/game_ctrl_fsm.sv
// Game state controller: RESET/START/PLAYING/PAUSE/GAMEOVER/RESPAWN/WIN with
// lives, level and respawn-timer counters; run_en gates render/physics/score.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int LIVES          = 3,
  parameter int LEVELS         = 8,
  parameter int RESPAWN_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetFSM,
  game_ctrl_fsm_if.slave      bus
);
  localparam int LW = $clog2(LIVES + 1);
  localparam int VW = width_of(LEVELS);
  localparam int TW = width_of(RESPAWN_CYCLES);

  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [VW-1:0] LEVEL_LAST = VW'(LEVELS - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESPAWN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [VW-1:0] level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          state_chg_q;
  logic          start_p, pause_p;

  rise_detect u_start_rd (
    .clk      (clk),
    .resetFSM (resetFSM),
    .in       (bus.startGame),
    .pulse    (start_p)
  );

  rise_detect u_pause_rd (
    .clk      (clk),
    .resetFSM (resetFSM),
    .in       (bus.pauseGame),
    .pulse    (pause_p)
  );

  always_ff @(posedge clk or posedge resetFSM) begin
    if (resetFSM) begin
      state_q     <= S_RESET;
      lives_q     <= LIVES_INIT;
      level_q     <= '0;
      timer_q     <= '0;
      state_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      timer_q     <= timer_d;
      state_chg_q <= (state_d != state_q);
    end
  end

  // NOTE: every signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    timer_d = timer_q;

    case (state_q)
      S_RESET: begin
        if (start_p) begin
          state_d = S_START;
          lives_d = LIVES_INIT;
          level_d = '0;
        end
      end

      S_START: begin
        if (bus.reset)    state_d = S_RESET;
        else if (start_p) state_d = S_PLAYING;
      end

      S_PLAYING: begin
        if (bus.reset) begin
          state_d = S_RESET;
        end else if (bus.dead) begin
          // The <= guard keeps lives from wrapping even if it somehow reached 0.
          if (lives_q <= LW'(1)) begin
            state_d = S_GAMEOVER;
            lives_d = '0;
          end else begin
            state_d = S_RESPAWN;
            lives_d = lives_q - LW'(1);
            timer_d = TIMER_LOAD;
          end
        end else if (bus.level_done) begin
          if (level_q >= LEVEL_LAST) state_d = S_WIN;
          else                       level_d = level_q + VW'(1);
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (bus.reset)    state_d = S_RESET;
        else if (pause_p) state_d = S_PLAYING;
      end

      S_RESPAWN: begin
        if (bus.reset)          state_d = S_RESET;
        else if (timer_q == '0) state_d = S_PLAYING;
        else                    timer_d = timer_q - TW'(1);
      end

      S_GAMEOVER, S_WIN: begin
        if (start_p) state_d = S_RESET;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign bus.dataout   = state_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.run_en    = (state_q == S_PLAYING);
  assign bus.state_chg = state_chg_q;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm with LIVES=3, LEVELS=8, RESPAWN_CYCLES=16.
// Expected values are hand-computed constants; outputs are sampled 1 ns after posedge.
module tb_game_ctrl_fsm;

  logic clk;
  logic resetFSM;
  int   tests_run;
  int   tests_failed;

  game_ctrl_fsm_if #(.LW(2), .VW(3)) bus ();

  game_ctrl_fsm #(
    .LIVES          (3),
    .LEVELS         (8),
    .RESPAWN_CYCLES (16)
  ) dut (
    .clk      (clk),
    .resetFSM (resetFSM),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release for one cycle then press: the state moves on the press edge.
  task automatic press_start();
    bus.startGame = 1'b0;
    tick();
    bus.startGame = 1'b1;
    tick();
    bus.startGame = 1'b0;
  endtask

  task automatic press_pause();
    bus.pauseGame = 1'b0;
    tick();
    bus.pauseGame = 1'b1;
    tick();
    bus.pauseGame = 1'b0;
  endtask

  task automatic pulse_dead();
    bus.dead = 1'b1;
    tick();
    bus.dead = 1'b0;
  endtask

  task automatic pulse_level();
    bus.level_done = 1'b1;
    tick();
    bus.level_done = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    resetFSM       = 1'b1;
    bus.reset      = 1'b0;
    bus.startGame  = 1'b1;
    bus.pauseGame  = 1'b0;
    bus.dead       = 1'b0;
    bus.level_done = 1'b0;

    // 1. start held through reset gives no edge; then press twice to reach PLAYING.
    #12 resetFSM = 1'b0;
    check("rst_dataout", bus.dataout, 3);
    check("rst_lives", bus.lives, 3);
    check("rst_level", bus.level, 0);
    check("rst_run_en", bus.run_en, 0);
    check("rst_state_chg", bus.state_chg, 0);
    tick(3);
    check("held_start_no_edge", bus.dataout, 3);
    press_start();
    check("start_dataout", bus.dataout, 0);
    check("start_state_chg", bus.state_chg, 1);
    tick();
    check("start_state_chg_clr", bus.state_chg, 0);
    press_start();
    check("play_dataout", bus.dataout, 1);
    check("play_run_en", bus.run_en, 1);

    // 2. Three deaths: two respawns of 16 cycles, then GAMEOVER.
    pulse_dead();
    check("d1_dataout", bus.dataout, 5);
    check("d1_lives", bus.lives, 2);
    check("d1_run_en", bus.run_en, 0);
    tick(15);
    check("d1_still_respawn", bus.dataout, 5);
    tick();
    check("d1_back_play", bus.dataout, 1);
    check("d1_back_chg", bus.state_chg, 1);
    pulse_dead();
    check("d2_lives", bus.lives, 1);
    tick(16);
    check("d2_back_play", bus.dataout, 1);
    pulse_dead();
    check("d3_dataout", bus.dataout, 4);
    check("d3_lives", bus.lives, 0);
    check("d3_run_en", bus.run_en, 0);
    tick(2);
    check("gameover_hold", bus.dataout, 4);
    press_start();
    check("gameover_to_reset", bus.dataout, 3);
    press_start();
    check("restart_lives", bus.lives, 3);
    press_start();
    check("restart_play", bus.dataout, 1);

    // 3. Seven level completions stay in PLAYING; the eighth wins.
    for (int i = 0; i < 7; i++) begin
      pulse_level();
      tick();
    end
    check("lvl_level7", bus.level, 7);
    check("lvl_still_play", bus.dataout, 1);
    check("lvl_no_chg", bus.state_chg, 0);
    pulse_level();
    check("win_dataout", bus.dataout, 6);
    check("win_level_hold", bus.level, 7);
    press_start();
    check("win_to_reset", bus.dataout, 3);
    press_start();
    check("newgame_level", bus.level, 0);
    press_start();
    check("newgame_play", bus.dataout, 1);

    // 4. Held pause enters PAUSE once; deaths ignored while paused.
    bus.pauseGame = 1'b1;
    tick();
    check("pause_enter", bus.dataout, 2);
    tick(9);
    check("pause_held", bus.dataout, 2);
    bus.pauseGame = 1'b0;
    pulse_dead();
    check("pause_dead_lives", bus.lives, 3);
    check("pause_dead_state", bus.dataout, 2);
    press_pause();
    check("unpause", bus.dataout, 1);

    // 5. Simultaneous dead + level_done: dead wins, level not advanced.
    pulse_dead();
    tick(16);
    check("pre_sim_lives", bus.lives, 2);
    bus.dead       = 1'b1;
    bus.level_done = 1'b1;
    tick();
    bus.dead       = 1'b0;
    bus.level_done = 1'b0;
    check("sim_dataout", bus.dataout, 5);
    check("sim_lives", bus.lives, 1);
    check("sim_level", bus.level, 0);
    tick(16);
    press_pause();
    check("sim_paused", bus.dataout, 2);
    bus.reset = 1'b1;
    tick();
    bus.reset = 1'b0;
    check("pause_soft_reset", bus.dataout, 3);

    // 6. Async resetFSM at respawn timer=5 acts without a clock edge.
    press_start();
    press_start();
    pulse_level();
    check("r6_level1", bus.level, 1);
    pulse_dead();
    tick(10);
    check("r6_in_respawn", bus.dataout, 5);
    #1 resetFSM = 1'b1;
    #1;
    check("async_dataout", bus.dataout, 3);
    check("async_lives", bus.lives, 3);
    check("async_level", bus.level, 0);
    check("async_state_chg", bus.state_chg, 0);
    @(negedge clk);
    resetFSM = 1'b0;
    tick(2);
    check("post_async_hold", bus.dataout, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
